verlet_integrator_array: RTL and testbench
==========================================

Name: verlet_integrator_array

Overview:
- Parametrised, fixed-point, multi-body position-Verlet integrator for the systolic n-body datapath.
- Holds q(t-dt) and q(t) for NBODY bodies in internal registers.
- Per time step it accepts one acceleration per body from the force array, in body order.
- It emits q(t+dt) = 2q(t) - q(t-dt) + a*dt^2 through a backpressured output stream and updates its stored state in place.

Parameters:
- W, 32: signed fixed-point width of positions, accelerations and dt^2.
- FRAC, 16: fractional bits (Q(W-FRAC).FRAC).
- NBODY, 8: bodies per step (>=2); IW = $clog2(NBODY).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  write initial state for body load_idx (IDLE only).
- load_idx  in  IW  body index for load.
- load_q_old  in  W  q(t-dt) to load.
- load_q  in  W  q(t) to load.
- start  in  1  one-cycle pulse: begin a step (IDLE only).
- cfg_dt2  in  W  dt^2 in Q format; sampled when start is accepted.
- acc_valid  in  1  acceleration valid.
- acc_ready  out  1  acceleration accepted when valid & ready.
- acc_data  in  W  acceleration of the current body.
- pos_valid  out  1  new position valid.
- pos_ready  in  1  downstream ready.
- pos_data  out  W  q(t+dt).
- pos_idx  out  IW  body index of pos_data.
- pos_last  out  1  asserted with body NBODY-1.
- busy  out  1  state != IDLE.
- step_done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; body counters and dt2 register cleared.
  - All q/q_old storage is 0.
  - Outputs: acc_ready=0, pos_valid=0, pos_data=0, pos_idx=0, pos_last=0, busy=0, step_done=0.
  - Reset mid-step aborts the step; no partial state is retained.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE:
    - load_en writes both words of body load_idx on the clock edge.
    - start captures cfg_dt2, clears the input counter, and moves to RUN.
    - If load_en and start are high in the same cycle, the load is performed first and the step then sees the loaded value.
  - RUN:
    - acc_ready = !stall, where stall = pos_valid & !pos_ready.
    - Each acceleration handshake applies to body in_cnt, which then increments.
    - The handshake on body NBODY-1 moves to DRAIN.
  - DRAIN:
    - acc_ready=0.
    - When the output handshake for body NBODY-1 completes (pos_valid & pos_ready & pos_last), go to IDLE and pulse step_done for 1 cycle.
  - Outside IDLE, load_en and start are ignored. acc_valid outside RUN is ignored.
- Pipeline: 2 stages, all stages stall together on stall.
  - Stage 1 (on an accepted acceleration) registers:
    - p = (acc_data * dt2) >>> FRAC, computed as a 2W-bit signed product with an arithmetic shift, i.e. rounding toward minus infinity.
    - s = 2*q[k] - q_old[k], computed in W+2 bits.
    - the index k.
  - Stage 2 computes r = s + p in 2W bits. The result is reduced to W bits per the optional feature. It is loaded into pos_data/pos_idx/pos_last, pos_valid is set, and in the same edge q_old[k]<=q[k], q[k]<=r.
  - Latency: pos_valid rises 2 cycles after the acceleration handshake when unstalled; sustained throughput is 1 body/cycle.
- Stream rules:
  - pos_valid stays high and pos_data stays stable until pos_ready.
  - pos_idx is strictly 0..NBODY-1 per step.
  - Back-to-back steps are allowed: start is accepted the cycle after step_done.

Optional Feature:
- VERLET_SAT_EN defined: the W-bit result saturates to [-2^(W-1), 2^(W-1)-1].
- VERLET_SAT_EN undefined: the W-bit result is the low W bits of r (two's-complement wrap).

Test Plan:
- Load body0 q_old=0x00018000 (1.5), q=0x00040000 (4.0); start with cfg_dt2=0x0000028F; acc=0x00010000 (1.0) -> pos_data=0x0006828F, pos_idx=0, exactly 2 cycles after the handshake; stored q_old=0x00040000, q=0x0006828F.
- NBODY=8, all bodies q=q_old=0x00010000, acc=0, pos_ready=1, acc_valid continuous -> 8 outputs on consecutive cycles, all 0x00010000; pos_last only on idx 7; step_done 1 cycle after that handshake; busy low on the same cycle.
- Random pos_ready (50%) over 3 back-to-back steps vs a software reference model -> no lost or duplicated bodies; pos_data stable while stalled; acc_ready=0 whenever stalled.
- q=0x7FFF0000, q_old=0, acc=0 -> 0xFFFE0000 without VERLET_SAT_EN; 0x7FFFFFFF with it. Also q=0x80000000, q_old=0 -> 0x00000000 (wrap) / 0x80000000 (sat).
- Pulse rst_n low after 3 of 8 accelerations -> all outputs 0 immediately; state IDLE; q storage reads back 0 in a following step with acc=0.
- start and load_en asserted during RUN -> ignored; dt2 and stored state unchanged; the step completes normally.

Source files
------------

// File: rtl/verlet_integrator_array.sv
// Multi-body fixed-point position-Verlet integrator: q(t+dt) = 2q(t) - q(t-dt) + a*dt^2.
// Define VERLET_SAT_EN to saturate results to W bits; otherwise results wrap.
module verlet_integrator_array #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int NBODY = 8,
  parameter int IW    = (NBODY > 1) ? $clog2(NBODY) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [IW-1:0] load_idx,
  input  logic [W-1:0]  load_q_old,
  input  logic [W-1:0]  load_q,
  input  logic          start,
  input  logic [W-1:0]  cfg_dt2,
  input  logic          acc_valid,
  output logic          acc_ready,
  input  logic [W-1:0]  acc_data,
  output logic          pos_valid,
  input  logic          pos_ready,
  output logic [W-1:0]  pos_data,
  output logic [IW-1:0] pos_idx,
  output logic          pos_last,
  output logic          busy,
  output logic          step_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  localparam logic [IW-1:0] LAST = IW'(NBODY - 1);

  state_e                 state_q;
  logic [W-1:0]           q_q     [NBODY];
  logic [W-1:0]           q_old_q [NBODY];
  logic [W-1:0]           dt2_q;
  logic [IW-1:0]          in_cnt_q;

  logic                   s1_valid_q;
  logic signed [2*W-1:0]  s1_p_q;
  logic signed [W+1:0]    s1_s_q;
  logic [IW-1:0]          s1_idx_q;

  logic                   pos_valid_q;
  logic [W-1:0]           pos_data_q;
  logic [IW-1:0]          pos_idx_q;
  logic                   pos_last_q;
  logic                   step_done_q;

  logic                   stall;
  logic                   acc_hs;
  logic                   out_hs;
  logic signed [2*W-1:0]  prod;
  logic signed [2*W-1:0]  p_d;
  logic [W-1:0]           q_k;
  logic [W-1:0]           qo_k;
  logic signed [W+1:0]    s_d;
  logic signed [2*W-1:0]  r;
  logic [W-1:0]           red;

  assign stall     = pos_valid_q & ~pos_ready;
  assign acc_ready = (state_q == S_RUN) & ~stall;
  assign acc_hs    = acc_valid & acc_ready;
  assign out_hs    = pos_valid_q & pos_ready;

  // Full-width signed product; the arithmetic shift floors toward minus infinity.
  assign prod = $signed({{W{acc_data[W-1]}}, acc_data}) * $signed({{W{dt2_q[W-1]}}, dt2_q});
  assign p_d  = prod >>> FRAC;

  assign q_k  = q_q[in_cnt_q];
  assign qo_k = q_old_q[in_cnt_q];
  assign s_d  = $signed({q_k[W-1], q_k, 1'b0}) - $signed({{2{qo_k[W-1]}}, qo_k});

  assign r = s1_p_q + $signed({{(W-2){s1_s_q[W+1]}}, s1_s_q});

`ifdef VERLET_SAT_EN
  localparam logic signed [2*W-1:0] R_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] R_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    red = r[W-1:0];
    if (r > R_MAX)      red = {1'b0, {(W-1){1'b1}}};
    else if (r < R_MIN) red = {1'b1, {(W-1){1'b0}}};
  end
`else
  assign red = W'(r);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dt2_q       <= '0;
      in_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_s_q      <= '0;
      s1_idx_q    <= '0;
      pos_valid_q <= 1'b0;
      pos_data_q  <= '0;
      pos_idx_q   <= '0;
      pos_last_q  <= 1'b0;
      step_done_q <= 1'b0;
      for (int i = 0; i < NBODY; i++) begin
        q_q[i]     <= '0;
        q_old_q[i] <= '0;
      end
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_en) begin
            q_old_q[load_idx] <= load_q_old;
            q_q[load_idx]     <= load_q;
          end
          if (start) begin
            dt2_q    <= cfg_dt2;
            in_cnt_q <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (acc_hs) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == LAST) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_hs && pos_last_q) begin
            state_q     <= S_IDLE;
            step_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Both stages advance together; a held output freezes the whole pipe.
      if (!stall) begin
        s1_valid_q <= acc_hs;
        if (acc_hs) begin
          s1_p_q   <= p_d;
          s1_s_q   <= s_d;
          s1_idx_q <= in_cnt_q;
        end
        pos_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          pos_data_q          <= red;
          pos_idx_q           <= s1_idx_q;
          pos_last_q          <= (s1_idx_q == LAST);
          q_old_q[s1_idx_q]   <= q_q[s1_idx_q];
          q_q[s1_idx_q]       <= red;
        end
      end
    end
  end

  assign pos_valid = pos_valid_q;
  assign pos_data  = pos_data_q;
  assign pos_idx   = pos_idx_q;
  assign pos_last  = pos_last_q;
  assign busy      = (state_q != S_IDLE);
  assign step_done = step_done_q;

endmodule

// File: tb/tb_verlet_integrator_array.sv
// Bench for verlet_integrator_array: vector table, directed corner sequences and
// randomized back-to-back steps against an arithmetic reference model.
module tb_verlet_integrator_array;
  localparam int W = 32, FRAC = 16, NB = 8, IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [W-1:0]  load_q_old = '0, load_q = '0;
  logic          start = 1'b0;
  logic [W-1:0]  cfg_dt2 = '0;
  logic          acc_valid = 1'b0;
  logic          acc_ready;
  logic [W-1:0]  acc_data = '0;
  logic          pos_valid;
  logic          pos_ready = 1'b0;
  logic [W-1:0]  pos_data;
  logic [IW-1:0] pos_idx;
  logic          pos_last, busy, step_done;

  verlet_integrator_array #(.W(W), .FRAC(FRAC), .NBODY(NB)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
    .load_q_old(load_q_old), .load_q(load_q), .start(start), .cfg_dt2(cfg_dt2),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
    .pos_idx(pos_idx), .pos_last(pos_last), .busy(busy), .step_done(step_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] mq [NB];
  logic [31:0] mqo[NB];
  logic [31:0] acc_v[NB];
  logic [31:0] got[NB];

  typedef struct {
    logic [31:0] qo, q, acc, dt2, exp_wrap, exp_sat;
  } vec_t;
  vec_t vecs[8];

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_pos(logic [31:0] qo, logic [31:0] q,
                                         logic [31:0] a, logic [31:0] d);
    longint s, p, r;
    s = 2 * longint'($signed(q)) - longint'($signed(qo));
    p = (longint'($signed(a)) * longint'($signed(d))) >>> FRAC;
    r = s + p;
`ifdef VERLET_SAT_EN
    if (r > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (r < -64'sd2147483648) return 32'h80000000;
`endif
    return 32'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_body(input int k, input logic [31:0] qo, input logic [31:0] q);
    @(negedge clk);
    load_en = 1'b1; load_idx = IW'(k); load_q_old = qo; load_q = q;
    @(negedge clk);
    load_en = 1'b0;
    mqo[k] = qo; mq[k] = q;
  endtask

  task automatic run_step(input logic [31:0] dt2, input int rdy_pct, input int val_pct,
                          input bit chk_lat, input int abort_after, input bit inject);
    logic [31:0] expv[NB];
    int hs_cyc[NB];
    int in_sent, out_cnt, last_out_cyc;
    bit prev_stall, done_pend, finished, injected;
    logic [31:0] prev_data;
    logic [IW-1:0] prev_idx;
    for (int k = 0; k < NB; k++) begin
      expv[k] = ref_pos(mqo[k], mq[k], acc_v[k], dt2);
      hs_cyc[k] = 0;
    end
    in_sent = 0; out_cnt = 0; last_out_cyc = 0;
    prev_stall = 0; done_pend = 0; finished = 0; injected = 0;
    prev_data = '0; prev_idx = '0;
    @(negedge clk);
    start = 1'b1; cfg_dt2 = dt2;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      if (abort_after >= 0 && in_sent == abort_after) begin
        acc_valid = 1'b0;
        return;
      end
      acc_valid = (in_sent < NB) && ($urandom_range(99) < val_pct);
      acc_data  = (in_sent < NB) ? acc_v[in_sent] : $urandom;
      pos_ready = ($urandom_range(99) < rdy_pct);
      if (inject && !injected && in_sent == 2) begin
        start = 1'b1; load_en = 1'b1; load_idx = 3'd5;
        load_q = $urandom; load_q_old = $urandom; cfg_dt2 = $urandom;
        injected = 1;
      end
      #1;
      if (cyc == 0) chk("busy_run", busy, 1);
      if (done_pend) begin
        chk("step_done", step_done, 1);
        chk("busy_end", busy, 0);
        chk("out_count", out_cnt, NB);
        finished = 1;
      end else begin
        if (pos_valid && !pos_ready) chk("acc_ready_stall", acc_ready, 0);
        if (prev_stall) begin
          chk("hold_valid", pos_valid, 1);
          chk("hold_data", pos_data, prev_data);
          chk("hold_idx", pos_idx, prev_idx);
        end
        if (pos_valid && pos_ready) begin
          if (out_cnt < NB) begin
            chk("pos_idx", pos_idx, out_cnt);
            chk($sformatf("pos_data_b%0d", out_cnt), pos_data, expv[out_cnt]);
            chk("pos_last", pos_last, out_cnt == NB - 1);
            got[out_cnt] = pos_data;
            if (chk_lat) begin
              chk("latency", cyc - hs_cyc[out_cnt], 2);
              if (out_cnt > 0) chk("throughput", cyc - last_out_cyc, 1);
            end
          end else begin
            chk("extra_output", out_cnt, NB - 1);
          end
          last_out_cyc = cyc;
          if (pos_last) done_pend = 1;
          out_cnt++;
        end
        if (acc_valid && acc_ready) begin
          if (in_sent < NB) hs_cyc[in_sent] = cyc;
          in_sent++;
        end
        prev_stall = pos_valid && !pos_ready;
        prev_data  = pos_data;
        prev_idx   = pos_idx;
      end
    end
    acc_valid = 1'b0;
    if (!finished) begin
      checks++; failures++;
      $display("FAIL step_timeout actual=%0d outputs required=%0d", out_cnt, NB);
    end else begin
      for (int k = 0; k < NB; k++) begin
        mqo[k] = mq[k];
        mq[k]  = expv[k];
      end
    end
  endtask

  initial begin
    vecs[0] = '{32'h00018000, 32'h00040000, 32'h00010000, 32'h0000028F, 32'h0006828F, 32'h0006828F};
    vecs[1] = '{32'h00000000, 32'h7FFF0000, 32'h00000000, 32'h0000028F, 32'hFFFE0000, 32'h7FFFFFFF};
    vecs[2] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h0000028F, 32'h00000000, 32'h80000000};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h00008000, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'h00020000, 32'h00010000, 32'h00020000, 32'h00010000, 32'h00020000, 32'h00020000};
    vecs[6] = '{32'hC0000000, 32'h40000000, 32'h00000000, 32'h00010000, 32'hC0000000, 32'h7FFFFFFF};
    vecs[7] = '{32'h00000000, 32'h00000000, 32'h00020000, 32'hFFFF0000, 32'hFFFE0000, 32'hFFFE0000};
    for (int k = 0; k < NB; k++) begin mq[k] = '0; mqo[k] = '0; acc_v[k] = '0; got[k] = '0; end

    #3 rst_n = 1'b0;
    #19;
    chk("rst_acc_ready", acc_ready, 0);
    chk("rst_pos_valid", pos_valid, 0);
    chk("rst_pos_data", pos_data, 0);
    chk("rst_pos_idx", pos_idx, 0);
    chk("rst_pos_last", pos_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_done", step_done, 0);
    @(negedge clk) rst_n = 1'b1;

    // Vector table on body 0; other bodies carry random accelerations through the model.
    for (int i = 0; i < 8; i++) begin
      load_body(0, vecs[i].qo, vecs[i].q);
      acc_v[0] = vecs[i].acc;
      for (int k = 1; k < NB; k++) acc_v[k] = $urandom;
      run_step(vecs[i].dt2, 100, 100, 1, -1, 0);
`ifdef VERLET_SAT_EN
      chk($sformatf("vec%0d", i), got[0], vecs[i].exp_sat);
`else
      chk($sformatf("vec%0d", i), got[0], vecs[i].exp_wrap);
`endif
    end

    // Stored state after the reference step: q_old=0x40000, q=0x6828F -> next = 0x9051E.
    load_body(0, 32'h00018000, 32'h00040000);
    acc_v[0] = 32'h00010000;
    run_step(32'h0000028F, 100, 100, 1, -1, 0);
    chk("ref_step", got[0], 32'h0006828F);
    for (int k = 0; k < NB; k++) acc_v[k] = '0;
    run_step(32'h0000028F, 100, 100, 1, -1, 0);
    chk("ref_stored", got[0], 32'h0009051E);

    // Steady state: all bodies at rest, full throughput.
    for (int k = 0; k < NB; k++) load_body(k, 32'h00010000, 32'h00010000);
    run_step(32'h00010000, 100, 100, 1, -1, 0);
    for (int k = 0; k < NB; k++) chk($sformatf("rest_b%0d", k), got[k], 32'h00010000);

    // Three back-to-back randomized steps under 50% backpressure.
    for (int k = 0; k < NB; k++) load_body(k, $urandom, $urandom);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NB; k++) acc_v[k] = $urandom;
      run_step($urandom, 50, 70, 0, -1, 0);
    end

    // start/load_en during RUN must be ignored; the following step confirms stored state.
    for (int k = 0; k < NB; k++) acc_v[k] = $urandom_range(32'h00FFFFFF);
    run_step(32'h00004000, 70, 80, 0, -1, 1);
    for (int k = 0; k < NB; k++) acc_v[k] = '0;
    run_step(32'h00004000, 60, 100, 0, -1, 0);

    // Reset after three accelerations aborts the step and clears storage.
    for (int k = 0; k < NB; k++) begin
      load_body(k, 32'h00030000, 32'h00050000);
      acc_v[k] = 32'h00010000;
    end
    run_step(32'h00010000, 100, 100, 0, 3, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_pos_valid", pos_valid, 0);
    chk("abort_pos_data", pos_data, 0);
    chk("abort_pos_idx", pos_idx, 0);
    chk("abort_acc_ready", acc_ready, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < NB; k++) begin mq[k] = '0; mqo[k] = '0; acc_v[k] = '0; end
    run_step(32'h00010000, 100, 100, 1, -1, 0);
    for (int k = 0; k < NB; k++) chk($sformatf("cleared_b%0d", k), got[k], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
